// File: rtl/dsp_slice_param_if.sv
// Signal bundle for dsp_slice_param: operands, mode select, per-register enables/resets and results.
interface dsp_slice_param_if #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int P_WIDTH = 48
);
    logic [A_WIDTH-1:0]         A;
    logic [B_WIDTH-1:0]         B, D, BCIN;
    logic [P_WIDTH-1:0]         C, PCIN;
    logic [7:0]                 OPMODE;
    logic                       CARRYIN;
    logic                       CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN;
    logic                       RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN;
    logic [B_WIDTH-1:0]         BCOUT;
    logic [A_WIDTH+B_WIDTH-1:0] M;
    logic [P_WIDTH-1:0]         P, PCOUT;
    logic                       CARRYOUT, CARRYOUTF, OVERFLOW;

    modport master (
        output A, B, D, BCIN, C, PCIN, OPMODE, CARRYIN,
        output CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN,
        output RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN,
        input  BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, OVERFLOW
    );

    modport slave (
        input  A, B, D, BCIN, C, PCIN, OPMODE, CARRYIN,
        input  CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN,
        input  RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN,
        output BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, OVERFLOW
    );
endinterface

// File: rtl/dsp_slice_param.sv
// Parametrised DSP slice: pre-adder, multiplier, post-adder/accumulator with optional saturation.
module dsp_slice_param #(
    parameter int A_WIDTH    = 18,
    parameter int B_WIDTH    = 18,
    parameter int P_WIDTH    = 48,
    parameter bit AREG       = 1'b1,
    parameter bit BREG       = 1'b1,
    parameter bit CREG       = 1'b1,
    parameter bit DREG       = 1'b1,
    parameter bit MREG       = 1'b1,
    parameter bit PREG       = 1'b1,
    parameter bit OPMODEREG  = 1'b1,
    parameter bit CARRYINREG = 1'b1,
    parameter bit B_INPUT    = 1'b0,
    parameter bit CARRYINSEL = 1'b0,
    parameter bit SAT_EN     = 1'b0
) (
    input logic              clk,
    input logic              RST,
    dsp_slice_param_if.slave bus
);
    localparam int M_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int DAB_WIDTH = 2 * B_WIDTH + A_WIDTH;

    function automatic logic [P_WIDTH:0] post_add(input logic [P_WIDTH-1:0] z,
                                                  input logic [P_WIDTH-1:0] x,
                                                  input logic cin, input logic sub);
        logic [P_WIDTH:0] xc;
        xc = {1'b0, x} + {{P_WIDTH{1'b0}}, cin};
        return sub ? ({1'b0, z} - xc) : ({1'b0, z} + xc);
    endfunction

    // Returns {overflow, p}; the top bit of raw is the carry on add and the borrow on subtract.
    function automatic logic [P_WIDTH:0] saturate(input logic [P_WIDTH:0] raw, input logic sub);
        logic ovf;
        ovf = SAT_EN && raw[P_WIDTH];
        if (!ovf) return {1'b0, raw[P_WIDTH-1:0]};
        return sub ? {1'b1, {P_WIDTH{1'b0}}} : {1'b1, {P_WIDTH{1'b1}}};
    endfunction

    logic [A_WIDTH-1:0] a_p1, a_s;
    logic [B_WIDTH-1:0] b_p1, b_s, d_p1, d_s, b_in;
    logic [P_WIDTH-1:0] c_p1, c_s;
    logic [7:0]         op_p1, op_s;
    logic               cin_p1, cin_s, cin_in;

    assign b_in   = B_INPUT ? bus.BCIN : bus.B;
    assign cin_in = CARRYINSEL ? bus.CARRYIN : bus.OPMODE[5];

    // Stage 1: operand, mode and carry-in registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            a_p1   <= '0;
            b_p1   <= '0;
            d_p1   <= '0;
            c_p1   <= '0;
            op_p1  <= '0;
            cin_p1 <= 1'b0;
        end else begin
            if (bus.RSTA) a_p1 <= '0;
            else if (bus.CEA) a_p1 <= bus.A;
            if (bus.RSTB) b_p1 <= '0;
            else if (bus.CEB) b_p1 <= b_in;
            if (bus.RSTD) d_p1 <= '0;
            else if (bus.CED) d_p1 <= bus.D;
            if (bus.RSTC) c_p1 <= '0;
            else if (bus.CEC) c_p1 <= bus.C;
            if (bus.RSTOPMODE) op_p1 <= '0;
            else if (bus.CEOPMODE) op_p1 <= bus.OPMODE;
            if (bus.RSTCARRYIN) cin_p1 <= 1'b0;
            else if (bus.CECARRYIN) cin_p1 <= cin_in;
        end
    end

    assign a_s   = AREG ? a_p1 : bus.A;
    assign b_s   = BREG ? b_p1 : b_in;
    assign d_s   = DREG ? d_p1 : bus.D;
    assign c_s   = CREG ? c_p1 : bus.C;
    assign op_s  = OPMODEREG ? op_p1 : bus.OPMODE;
    assign cin_s = CARRYINREG ? cin_p1 : cin_in;

    logic [B_WIDTH-1:0] preadd, bcout;
    logic [M_WIDTH-1:0] m_comb, m_p2, m_s;

    assign preadd = op_s[6] ? (d_s - b_s) : (d_s + b_s);
    assign bcout  = op_s[4] ? preadd : b_s;
    assign m_comb = {{B_WIDTH{1'b0}}, a_s} * {{A_WIDTH{1'b0}}, bcout};

    // Stage 2: multiplier register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) m_p2 <= '0;
        else if (bus.RSTM) m_p2 <= '0;
        else if (bus.CEM) m_p2 <= m_comb;
    end

    assign m_s = MREG ? m_p2 : m_comb;

    logic [DAB_WIDTH-1:0] dab;
    logic [P_WIDTH-1:0]   x_mux, z_mux, p_p3, p_comb;
    logic [P_WIDTH:0]     post_raw, sat_res;
    logic                 co_comb, ovf_comb, co_p3, ovf_p3;

    assign dab = {d_s, a_s, b_s};

    // Feedback always taps the P register so a bypassed P stage cannot form a loop.
    always_comb begin
        x_mux = '0;
        case (op_s[1:0])
            2'd1:    x_mux = P_WIDTH'(m_s);
            2'd2:    x_mux = p_p3;
            2'd3:    x_mux = P_WIDTH'(dab);
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (op_s[3:2])
            2'd1:    z_mux = bus.PCIN;
            2'd2:    z_mux = p_p3;
            2'd3:    z_mux = c_s;
            default: z_mux = '0;
        endcase
    end

    assign post_raw = post_add(z_mux, x_mux, cin_s, op_s[7]);
    assign sat_res  = saturate(post_raw, op_s[7]);
    assign co_comb  = post_raw[P_WIDTH];
    assign ovf_comb = sat_res[P_WIDTH];
    assign p_comb   = sat_res[P_WIDTH-1:0];

    // Stage 3: result, overflow and carry-out registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            p_p3   <= '0;
            ovf_p3 <= 1'b0;
            co_p3  <= 1'b0;
        end else begin
            if (bus.RSTP) begin
                p_p3   <= '0;
                ovf_p3 <= 1'b0;
            end else if (bus.CEP) begin
                p_p3   <= p_comb;
                ovf_p3 <= ovf_comb;
            end
            if (bus.RSTCARRYIN) co_p3 <= 1'b0;
            else if (bus.CECARRYIN) co_p3 <= co_comb;
        end
    end

    assign bus.BCOUT     = bcout;
    assign bus.M         = m_s;
    assign bus.P         = PREG ? p_p3 : p_comb;
    assign bus.PCOUT     = bus.P;
    assign bus.CARRYOUT  = PREG ? co_p3 : co_comb;
    assign bus.CARRYOUTF = bus.CARRYOUT;
    assign bus.OVERFLOW  = PREG ? ovf_p3 : ovf_comb;
endmodule

// File: tb/tb_dsp_slice_param.sv
// Bench for dsp_slice_param: wrap and saturating slices against an arithmetic model, plus a fully bypassed slice.
module tb_dsp_slice_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    dsp_slice_param_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) bus0 ();
    dsp_slice_param_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) bus1 ();
    dsp_slice_param_if #(.A_WIDTH(25), .B_WIDTH(18), .P_WIDTH(48)) bus2 ();

    assign bus1.A = bus0.A;       assign bus1.B = bus0.B;         assign bus1.D = bus0.D;
    assign bus1.BCIN = bus0.BCIN; assign bus1.C = bus0.C;         assign bus1.PCIN = bus0.PCIN;
    assign bus1.OPMODE = bus0.OPMODE; assign bus1.CARRYIN = bus0.CARRYIN;
    assign bus1.CEA = bus0.CEA;   assign bus1.CEB = bus0.CEB;     assign bus1.CEC = bus0.CEC;
    assign bus1.CED = bus0.CED;   assign bus1.CEM = bus0.CEM;     assign bus1.CEP = bus0.CEP;
    assign bus1.CEOPMODE = bus0.CEOPMODE; assign bus1.CECARRYIN = bus0.CECARRYIN;
    assign bus1.RSTA = bus0.RSTA; assign bus1.RSTB = bus0.RSTB;   assign bus1.RSTC = bus0.RSTC;
    assign bus1.RSTD = bus0.RSTD; assign bus1.RSTM = bus0.RSTM;   assign bus1.RSTP = bus0.RSTP;
    assign bus1.RSTOPMODE = bus0.RSTOPMODE; assign bus1.RSTCARRYIN = bus0.RSTCARRYIN;

    dsp_slice_param #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SAT_EN(1'b0))
        u0 (.clk(clk), .RST(rst), .bus(bus0));
    dsp_slice_param #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SAT_EN(1'b1))
        u1 (.clk(clk), .RST(rst), .bus(bus1));
    dsp_slice_param #(.A_WIDTH(25), .B_WIDTH(18), .P_WIDTH(48),
                      .AREG(1'b0), .BREG(1'b0), .CREG(1'b0), .DREG(1'b0), .MREG(1'b0),
                      .PREG(1'b0), .OPMODEREG(1'b0), .CARRYINREG(1'b0), .SAT_EN(1'b0))
        u2 (.clk(clk), .RST(rst), .bus(bus2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [17:0] ma, mb, md;
    logic [47:0] mc, mpw, mps;
    logic [7:0]  mop;
    logic        mcin, mcow, mcos, movs;
    logic [35:0] mm;

    function automatic logic [17:0] bc_of(input logic [7:0] op, input logic [17:0] d, input logic [17:0] b);
        if (!op[4]) return b;
        if (op[6]) return d - b;
        return d + b;
    endfunction

    function automatic logic [47:0] x_of(input logic [7:0] op, input logic [35:0] m, input logic [47:0] p,
                                         input logic [17:0] d, input logic [17:0] a, input logic [17:0] b);
        logic [53:0] dab;
        dab = {d, a, b};
        case (op[1:0])
            2'd0:    return '0;
            2'd1:    return {12'd0, m};
            2'd2:    return p;
            default: return dab[47:0];
        endcase
    endfunction

    function automatic logic [47:0] z_of(input logic [7:0] op, input logic [47:0] pcin,
                                         input logic [47:0] p, input logic [47:0] c);
        case (op[3:2])
            2'd0:    return '0;
            2'd1:    return pcin;
            2'd2:    return p;
            default: return c;
        endcase
    endfunction

    // Returns {overflow, carry/borrow, p}.
    function automatic logic [49:0] post(input logic [47:0] z, input logic [47:0] x,
                                         input logic cin, input logic sub, input logic sat);
        longint unsigned zz, xx, cc, r;
        logic co, ov;
        logic [47:0] p;
        zz = {16'd0, z};
        xx = {16'd0, x};
        cc = {63'd0, cin};
        if (!sub) begin
            r  = zz + xx + cc;
            co = (r >= 64'h1_0000_0000_0000);
            ov = sat && co;
            p  = ov ? '1 : r[47:0];
        end else begin
            co = ((xx + cc) > zz);
            r  = zz - xx - cc;
            ov = sat && co;
            p  = ov ? '0 : r[47:0];
        end
        return {ov, co, p};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [49:0] rw, rs;
        logic [35:0] mn;
        if (rst) begin
            ma = '0; mb = '0; md = '0; mc = '0; mop = '0; mcin = 1'b0;
            mm = '0; mpw = '0; mps = '0; mcow = 1'b0; mcos = 1'b0; movs = 1'b0;
        end else begin
            rw = post(z_of(mop, bus0.PCIN, mpw, mc), x_of(mop, mm, mpw, md, ma, mb), mcin, mop[7], 1'b0);
            rs = post(z_of(mop, bus0.PCIN, mps, mc), x_of(mop, mm, mps, md, ma, mb), mcin, mop[7], 1'b1);
            mn = {18'd0, ma} * {18'd0, bc_of(mop, md, mb)};
            if (bus0.RSTP) begin
                mpw = '0; mps = '0; movs = 1'b0;
            end else if (bus0.CEP) begin
                mpw = rw[47:0]; mps = rs[47:0]; movs = rs[49];
            end
            if (bus0.RSTCARRYIN) begin
                mcow = 1'b0; mcos = 1'b0; mcin = 1'b0;
            end else if (bus0.CECARRYIN) begin
                mcow = rw[48]; mcos = rs[48]; mcin = bus0.OPMODE[5];
            end
            if (bus0.RSTM) mm = '0; else if (bus0.CEM) mm = mn;
            if (bus0.RSTA) ma = '0; else if (bus0.CEA) ma = bus0.A;
            if (bus0.RSTB) mb = '0; else if (bus0.CEB) mb = bus0.B;
            if (bus0.RSTD) md = '0; else if (bus0.CED) md = bus0.D;
            if (bus0.RSTC) mc = '0; else if (bus0.CEC) mc = bus0.C;
            if (bus0.RSTOPMODE) mop = '0; else if (bus0.CEOPMODE) mop = bus0.OPMODE;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("p_wrap",      64'(bus0.P),         64'(mpw));
            chk("pcout_wrap",  64'(bus0.PCOUT),     64'(mpw));
            chk("co_wrap",     64'(bus0.CARRYOUT),  64'(mcow));
            chk("cof_wrap",    64'(bus0.CARRYOUTF), 64'(mcow));
            chk("ovf_wrap",    64'(bus0.OVERFLOW),  64'd0);
            chk("m_wrap",      64'(bus0.M),         64'(mm));
            chk("bcout_wrap",  64'(bus0.BCOUT),     64'(bc_of(mop, md, mb)));
            chk("p_sat",       64'(bus1.P),         64'(mps));
            chk("co_sat",      64'(bus1.CARRYOUT),  64'(mcos));
            chk("ovf_sat",     64'(bus1.OVERFLOW),  64'(movs));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] d, input logic [47:0] c);
        bus0.OPMODE = op; bus0.A = a; bus0.B = b; bus0.D = d; bus0.C = c;
    endtask

    task automatic set_ctrl(input logic ce, input logic rs);
        bus0.CEA = ce; bus0.CEB = ce; bus0.CEC = ce; bus0.CED = ce;
        bus0.CEM = ce; bus0.CEP = ce; bus0.CEOPMODE = ce; bus0.CECARRYIN = ce;
        bus0.RSTA = rs; bus0.RSTB = rs; bus0.RSTC = rs; bus0.RSTD = rs;
        bus0.RSTM = rs; bus0.RSTP = rs; bus0.RSTOPMODE = rs; bus0.RSTCARRYIN = rs;
    endtask

    initial begin
        logic [63:0] e;
        drive(8'h00, '0, '0, '0, '0);
        bus0.BCIN = '0; bus0.PCIN = '0; bus0.CARRYIN = 1'b0;
        set_ctrl(1'b1, 1'b0);
        bus2.A = '0; bus2.B = '0; bus2.D = '0; bus2.BCIN = '0; bus2.C = '0; bus2.PCIN = '0;
        bus2.OPMODE = 8'h00; bus2.CARRYIN = 1'b0;
        bus2.CEA = 1'b1; bus2.CEB = 1'b1; bus2.CEC = 1'b1; bus2.CED = 1'b1;
        bus2.CEM = 1'b1; bus2.CEP = 1'b1; bus2.CEOPMODE = 1'b1; bus2.CECARRYIN = 1'b1;
        bus2.RSTA = 1'b0; bus2.RSTB = 1'b0; bus2.RSTC = 1'b0; bus2.RSTD = 1'b0;
        bus2.RSTM = 1'b0; bus2.RSTP = 1'b0; bus2.RSTOPMODE = 1'b0; bus2.RSTCARRYIN = 1'b0;

        step(2);
        chk("reset_p", 64'(bus0.P), 64'd0);
        chk("reset_m", 64'(bus0.M), 64'd0);
        rst = 1'b0;
        checking = 1'b1;

        // pre-add, multiply, add C
        drive(8'h1D, 18'd4, 18'd3, 18'd5, 48'd100);
        step(2);
        chk("preadd_m", 64'(bus0.M), 64'd32);
        step(1);
        chk("preadd_p", 64'(bus0.P), 64'd132);
        chk("preadd_co", 64'(bus0.CARRYOUT), 64'd0);

        // accumulate with RSTP clear and CEP hold
        drive(8'h09, 18'd2, 18'd3, 18'd0, 48'd0);
        bus0.RSTP = 1'b1;
        step(1);
        chk("rstp_clear", 64'(bus0.P), 64'd0);
        step(1);
        bus0.RSTP = 1'b0;
        step(1); chk("acc_6",  64'(bus0.P), 64'd6);
        step(1); chk("acc_12", 64'(bus0.P), 64'd12);
        step(1); chk("acc_18", 64'(bus0.P), 64'd18);
        bus0.CEP = 1'b0;
        step(1); chk("acc_hold", 64'(bus0.P), 64'd18);
        bus0.CEP = 1'b1;
        step(1); chk("acc_24", 64'(bus0.P), 64'd24);

        // add overflow
        drive(8'h0D, 18'd1, 18'd32, 18'd0, 48'hFFFF_FFFF_FFF0);
        step(3);
        chk("sat_add_p",   64'(bus1.P),        64'h0000_FFFF_FFFF_FFFF);
        chk("sat_add_ovf", 64'(bus1.OVERFLOW), 64'd1);
        chk("sat_add_co",  64'(bus1.CARRYOUT), 64'd1);
        chk("wrap_add_p",  64'(bus0.P),        64'h10);
        chk("wrap_add_ovf",64'(bus0.OVERFLOW), 64'd0);

        // subtract underflow
        drive(8'h8D, 18'd2, 18'd3, 18'd0, 48'd5);
        step(3);
        chk("sat_sub_p",   64'(bus1.P),        64'd0);
        chk("sat_sub_ovf", 64'(bus1.OVERFLOW), 64'd1);
        chk("wrap_sub_p",  64'(bus0.P),        64'h0000_FFFF_FFFF_FFFF);
        chk("wrap_sub_co", 64'(bus0.CARRYOUT), 64'd1);

        // async reset mid-cycle during accumulation
        drive(8'h09, 18'd2, 18'd3, 18'd0, 48'd0);
        step(4);
        rst = 1'b1;
        #2;
        chk("arst_p",   64'(bus0.P),        64'd0);
        chk("arst_m",   64'(bus0.M),        64'd0);
        chk("arst_co",  64'(bus0.CARRYOUT), 64'd0);
        chk("arst_ovf", 64'(bus1.OVERFLOW), 64'd0);
        chk("arst_p1",  64'(bus1.P),        64'd0);
        #1;
        rst = 1'b0;
        step(3);
        chk("arst_restart", 64'(bus0.P), 64'd6);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            bus0.A = 18'($urandom); bus0.B = 18'($urandom); bus0.D = 18'($urandom);
            bus0.BCIN = 18'($urandom);
            bus0.C = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) bus0.C = 48'hFFFF_FFFF_FF00 | 48'($urandom_range(0, 255));
            bus0.PCIN = 48'({$urandom(), $urandom()});
            bus0.OPMODE = 8'($urandom);
            bus0.CARRYIN = 1'($urandom);
            set_ctrl(1'b1, 1'b0);
            bus0.CEA = ($urandom_range(0, 9) != 0); bus0.CEM = ($urandom_range(0, 9) != 0);
            bus0.CEP = ($urandom_range(0, 9) != 0); bus0.CEOPMODE = ($urandom_range(0, 9) != 0);
            bus0.CEC = ($urandom_range(0, 9) != 0); bus0.CECARRYIN = ($urandom_range(0, 9) != 0);
            bus0.RSTB = ($urandom_range(0, 19) == 0); bus0.RSTP = ($urandom_range(0, 19) == 0);
            bus0.RSTM = ($urandom_range(0, 19) == 0); bus0.RSTCARRYIN = ($urandom_range(0, 19) == 0);
            step(1);
        end
        set_ctrl(1'b1, 1'b0);

        // fully bypassed slice, wide A
        bus2.OPMODE = 8'h0D; bus2.A = 25'h100_0000; bus2.B = 18'd2; bus2.C = 48'd1;
        #1;
        chk("bypass_p", 64'(bus2.P), 64'h200_0001);
        for (int i = 0; i < 10; i++) begin
            bus2.A = 25'($urandom); bus2.B = 18'($urandom);
            bus2.C = 48'({$urandom(), $urandom()});
            #1;
            e = 64'(bus2.C) + 64'(bus2.A) * 64'(bus2.B);
            chk("bypass_rand_p",  64'(bus2.P),        {16'd0, e[47:0]});
            chk("bypass_rand_co", 64'(bus2.CARRYOUT), {63'd0, e[48]});
            chk("bypass_rand_m",  64'(bus2.M),        64'(bus2.A) * 64'(bus2.B));
        end

        step(2);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
